// File: rtl/lcd_writer.sv
// HD44780-style LCD write engine: accepts one byte + RS per handshake and generates setup/EN/hold/exec timing.
// Optional LCD_WRITER_LONG_CMD_EN: clear/home commands (RS=0, DATA 0x01..0x03) use LONG_EXEC_CYC in EXEC.
module lcd_writer #(
    parameter int unsigned SETUP_CYC     = 4,
    parameter int unsigned PULSE_CYC     = 25,
    parameter int unsigned HOLD_CYC      = 4,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned LONG_EXEC_CYC = 80000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rs_i,
    input  logic [7:0]  req_data_i,
    input  logic        lcd_on_i,
    output logic [31:0] io_lcd_o,
    output logic        done_o
);

    localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_SPH = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
`ifdef LCD_WRITER_LONG_CMD_EN
    localparam int unsigned MAX_E   = (EXEC_CYC > LONG_EXEC_CYC) ? EXEC_CYC : LONG_EXEC_CYC;
`else
    localparam int unsigned MAX_E   = EXEC_CYC;
`endif
    localparam int unsigned MAXC    = (MAX_SPH > MAX_E) ? MAX_SPH : MAX_E;
    localparam int unsigned CW      = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic          on_q;
    logic [CW-1:0] exec_load;

`ifdef LCD_WRITER_LONG_CMD_EN
    logic long_q, long_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) long_q <= 1'b0;
        else         long_q <= long_d;
    end

    always_comb begin
        long_d = long_q;
        if (state_q == IDLE && req_valid_i)
            long_d = !req_rs_i && (req_data_i inside {8'h01, 8'h02, 8'h03});
    end

    assign exec_load = long_q ? CW'(LONG_EXEC_CYC - 1) : CW'(EXEC_CYC - 1);
`else
    assign exec_load = CW'(EXEC_CYC - 1);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            done_q  <= done_d;
            on_q    <= lcd_on_i;
        end
    end

    // Each timed state loads cnt with (length-1) on entry and leaves when it reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                rs_d    = req_rs_i;
                data_d  = req_data_i;
                state_d = SETUP;
                cnt_d   = CW'(SETUP_CYC - 1);
            end
            SETUP: if (cnt_q == '0) begin
                state_d = PULSE;
                cnt_d   = CW'(PULSE_CYC - 1);
            end else cnt_d = cnt_q - CW'(1);
            PULSE: if (cnt_q == '0) begin
                state_d = HOLD;
                cnt_d   = CW'(HOLD_CYC - 1);
            end else cnt_d = cnt_q - CW'(1);
            HOLD: if (cnt_q == '0) begin
                state_d = EXEC;
                cnt_d   = exec_load;
            end else cnt_d = cnt_q - CW'(1);
            EXEC: if (cnt_q == '0) state_d = IDLE;
                  else cnt_d = cnt_q - CW'(1);
            default: state_d = IDLE;
        endcase
        // EN and done are registered from next-state so the pins never glitch on decode.
        en_d   = (state_d == PULSE);
        done_d = (state_d == EXEC) && (cnt_d == '0);
    end

    assign req_ready_o = (state_q == IDLE);
    assign done_o      = done_q;
    assign io_lcd_o    = {on_q, 20'b0, en_q, rs_q, 1'b0, data_q};

endmodule
